// File: rtl/cache_pkg.sv
// Shared cache constants, fill-FSM state encoding and block/word address helper.
// Used by the fill FSM, the cache controller and the tag/data arrays.
package cache_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned WORDS       = 8;  // words per block, power of 2
  // Informational only: the FSM counts valids instead of cycles.
  localparam int unsigned MEM_LATENCY = 4;

  localparam int unsigned BLOCK_BYTES = 2 * WORDS;
  localparam int unsigned OFFSET_W    = $clog2(BLOCK_BYTES);
  localparam int unsigned WIDX_W      = $clog2(WORDS);
  // Word index plus a done bit.
  localparam int unsigned CNT_W       = WIDX_W + 1;
  localparam int unsigned BLK_W       = ADDR_W - OFFSET_W;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  // Byte address of word idx inside block blk. The offset never carries
  // into the block number, so a fill cannot wrap out of its block.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [BLK_W-1:0]  blk,
                                                  input logic [WIDX_W-1:0] idx);
    return {blk, idx, 1'b0};
  endfunction

endpackage

// File: rtl/fill_counter.sv
// Clearable up-counter used for the issue and receive word counts of a fill.
// Ports: clk, rst_n (async active-low), clr (sync clear, wins over inc),
//        inc (count up by one), cnt (current count).
module fill_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] cnt
);

  logic [Width-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + Width'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: fetches the block holding miss_address from memory with
// WORDS back-to-back word reads, streams returned words into the data array and
// writes the tag on the last word. fsm_busy stalls the pipeline for the fill.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   miss_detected/miss_address miss request (level) and faulting byte address
//   memory_data/_valid         memory read return
//   fsm_busy                   fill in progress
//   memory_read/_address       read request to memory
//   write_data_array, cache_word_address, cache_word_data  data array write
//   write_tag_array            tag/valid write for the block
// Configuration macro: CACHE_FILL_CRITICAL_WORD_FIRST_EN starts issue and
// receive order at the missing word and wraps within the block.
module cache_fill_fsm
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [DATA_W-1:0] memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              memory_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] cache_word_address,
  output logic [DATA_W-1:0] cache_word_data,
  output logic              write_tag_array
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(WORDS - 1);

  fill_state_e       r_state, w_state_next;
  logic [BLK_W-1:0]  r_blk;
  logic [CNT_W-1:0]  w_issue_cnt, w_rcv_cnt;
  logic              w_clr, w_issue_inc, w_rcv_inc;
  logic [WIDX_W-1:0] w_issue_idx, w_rcv_idx;
  logic              w_unused_addr;

  assign w_unused_addr = ^miss_address[OFFSET_W-1:0];

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  logic [WIDX_W-1:0] r_w0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w0 <= '0;
    end else if (r_state == IDLE && miss_detected) begin
      r_w0 <= miss_address[OFFSET_W-1:1];
    end
  end

  // Index addition wraps mod WORDS by truncation.
  assign w_issue_idx = w_issue_cnt[WIDX_W-1:0] + r_w0;
  assign w_rcv_idx   = w_rcv_cnt[WIDX_W-1:0] + r_w0;
`else
  assign w_issue_idx = w_issue_cnt[WIDX_W-1:0];
  assign w_rcv_idx   = w_rcv_cnt[WIDX_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_blk   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && miss_detected) begin
        r_blk <= miss_address[ADDR_W-1:OFFSET_W];
      end
    end
  end

  // Counters sit at zero throughout IDLE, so they start clean on acceptance.
  assign w_clr = (r_state == IDLE);

  fill_counter #(
    .Width(CNT_W)
  ) u_issue_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_clr),
    .inc  (w_issue_inc),
    .cnt  (w_issue_cnt)
  );

  fill_counter #(
    .Width(CNT_W)
  ) u_rcv_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_clr),
    .inc  (w_rcv_inc),
    .cnt  (w_rcv_cnt)
  );

  assign cache_word_data = memory_data;

  always_comb begin
    w_state_next       = r_state;
    fsm_busy           = 1'b0;
    memory_read        = 1'b0;
    memory_address     = '0;
    write_data_array   = 1'b0;
    cache_word_address = '0;
    write_tag_array    = 1'b0;
    w_issue_inc        = 1'b0;
    w_rcv_inc          = 1'b0;
    case (r_state)
      IDLE: begin
        if (miss_detected) begin
          w_state_next = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        // Done bit of the issue count ends the request burst.
        if (!w_issue_cnt[WIDX_W]) begin
          memory_read    = 1'b1;
          memory_address = word_addr(r_blk, w_issue_idx);
          w_issue_inc    = 1'b1;
        end
        // Valids with no outstanding request are dropped.
        if (memory_data_valid && (w_rcv_cnt < w_issue_cnt)) begin
          write_data_array   = 1'b1;
          cache_word_address = word_addr(r_blk, w_rcv_idx);
          w_rcv_inc          = 1'b1;
          if (w_rcv_cnt == LastIdx) begin
            write_tag_array = 1'b1;
            w_state_next    = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule
